// File: rtl/eth_send_ctrl.sv
// Packet send controller: buffers 32-bit payload words in a FIFO and hands
// full (or flushed partial) packets to a downstream UDP transmitter.
module eth_send_ctrl #(
  parameter int PKT_WORDS = 256,
  parameter int FIFO_AW   = 10,
  parameter int IDLE_GAP  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic        flush,
  input  logic        read_data_req,
  input  logic        send_end,
  output logic        send_en,
  output logic [31:0] send_data,
  output logic [15:0] send_data_num,
  output logic        fifo_full,
  output logic        busy,
  output logic [15:0] pkt_cnt,
  output logic [1:0]  err
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_LVL = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] PKT_LVL   = (FIFO_AW+1)'(PKT_WORDS);
  localparam logic [15:0]      PKT_BYTES = 16'(PKT_WORDS * 4);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] START    = 2'd1;
  localparam logic [1:0] WAIT_END = 2'd2;
  localparam logic [1:0] GAP      = 2'd3;

  logic [31:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [FIFO_AW:0]   word_cnt_reg, word_cnt_next;
  logic [31:0]        send_data_reg;
  logic               full, empty, do_wr, do_rd;

  logic [1:0]  state_reg, state_next;
  logic        flush_pend_reg, flush_clr;
  logic [15:0] gap_cnt_reg;
  logic [15:0] num_reg, num_next;
  logic [15:0] pkt_cnt_reg;
  logic [1:0]  err_reg, err_set, err_next;
  logic        pkt_done;

  assign full  = (word_cnt_reg == DEPTH_LVL);
  assign empty = (word_cnt_reg == '0);
  assign do_wr = wr_en & ~full;
  assign do_rd = read_data_req & ~empty;

  // Overflow and underflow flags latch until reset.
  assign err_set[0] = wr_en & full;
  assign err_set[1] = read_data_req & empty;
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_err
      assign err_next[gi] = err_reg[gi] | err_set[gi];
    end
  endgenerate

  always_comb begin
    word_cnt_next = word_cnt_reg;
    case ({do_wr, do_rd})
      2'b10:   word_cnt_next = word_cnt_reg + (FIFO_AW+1)'(1);
      2'b01:   word_cnt_next = word_cnt_reg - (FIFO_AW+1)'(1);
      default: word_cnt_next = word_cnt_reg;
    endcase
  end

  assign pkt_done = (state_reg == WAIT_END) & send_end;

  always_comb begin
    state_next = state_reg;
    num_next   = num_reg;
    flush_clr  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (word_cnt_reg >= PKT_LVL) begin
          num_next   = PKT_BYTES;
          flush_clr  = 1'b1;
          state_next = START;
        end else if (flush_pend_reg) begin
          // A flush with nothing buffered is simply consumed.
          flush_clr = 1'b1;
          if (!empty) begin
            num_next   = 16'({word_cnt_reg, 2'b00});
            state_next = START;
          end
        end
      end
      START:    state_next = WAIT_END;
      WAIT_END: if (send_end) state_next = GAP;
      GAP:      if (gap_cnt_reg <= 16'd1) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      word_cnt_reg   <= '0;
      send_data_reg  <= '0;
      state_reg      <= IDLE;
      flush_pend_reg <= 1'b0;
      gap_cnt_reg    <= '0;
      num_reg        <= '0;
      pkt_cnt_reg    <= '0;
      err_reg        <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + FIFO_AW'(1);
      if (do_rd) begin
        rd_ptr_reg    <= rd_ptr_reg + FIFO_AW'(1);
        send_data_reg <= mem[rd_ptr_reg];
      end
      word_cnt_reg   <= word_cnt_next;
      state_reg      <= state_next;
      num_reg        <= num_next;
      // A flush arriving in the same cycle as a clear stays pending.
      flush_pend_reg <= flush | (flush_pend_reg & ~flush_clr);
      err_reg        <= err_next;
      if (pkt_done) begin
        pkt_cnt_reg <= pkt_cnt_reg + 16'd1;
        gap_cnt_reg <= 16'(IDLE_GAP);
      end else if (state_reg == GAP) begin
        gap_cnt_reg <= gap_cnt_reg - 16'd1;
      end
    end
  end

  assign send_en       = (state_reg == START);
  assign busy          = (state_reg != IDLE);
  assign send_data     = send_data_reg;
  assign send_data_num = num_reg;
  assign fifo_full     = full;
  assign pkt_cnt       = pkt_cnt_reg;
  assign err           = err_reg;

endmodule

// File: tb/tb_eth_send_ctrl.sv
// Randomized bench for eth_send_ctrl: a queue-based reference model with a
// packet timeline is compared against every output after every clock edge.
module tb_eth_send_ctrl;

  localparam int PKT_WORDS = 256;
  localparam int FIFO_AW   = 10;
  localparam int IDLE_GAP  = 16;
  localparam int DEPTH     = 1 << FIFO_AW;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic        flush = 1'b0;
  logic        read_data_req = 1'b0;
  logic        send_end = 1'b0;
  logic        send_en;
  logic [31:0] send_data;
  logic [15:0] send_data_num;
  logic        fifo_full;
  logic        busy;
  logic [15:0] pkt_cnt;
  logic [1:0]  err;

  eth_send_ctrl #(
    .PKT_WORDS(PKT_WORDS),
    .FIFO_AW  (FIFO_AW),
    .IDLE_GAP (IDLE_GAP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .flush        (flush),
    .read_data_req(read_data_req),
    .send_end     (send_end),
    .send_en      (send_en),
    .send_data    (send_data),
    .send_data_num(send_data_num),
    .fifo_full    (fifo_full),
    .busy         (busy),
    .pkt_cnt      (pkt_cnt),
    .err          (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model: payload queue plus a timeline of packet events.
  logic [31:0] q[$];
  bit          m_pend;
  logic [15:0] m_pkt_cnt;
  logic [1:0]  m_err;
  logic [31:0] m_data;
  logic [15:0] m_num;
  bit          m_active;
  bit          m_send_en;
  bit          m_accept;
  longint      k = 0;
  longint      start_edge = 0;
  longint      idle_from = 0;

  // Observations and downstream emulation.
  int          starts_seen = 0;
  logic [15:0] last_num = '0;
  longint      last_end_edge = -1;
  longint      min_gap = 1000000;
  int          ds_left = 0;
  bit          ds_wait = 0;

  task automatic model_edge(input logic w, input logic [31:0] d, input logic f,
                            input logic r, input logic e, input logic rs);
    int sz;
    bit clr;
    k++;
    m_send_en = 0;
    m_accept  = 0;
    if (rs) begin
      q.delete();
      m_pend = 0; m_pkt_cnt = '0; m_err = '0; m_data = '0; m_num = '0;
      m_active = 0; idle_from = k + 1;
      return;
    end
    sz  = q.size();
    clr = 0;
    // A packet can end only once its start cycle has passed.
    if (m_active && e && k >= start_edge + 2) begin
      m_pkt_cnt = m_pkt_cnt + 16'd1;
      m_active  = 0;
      idle_from = k + IDLE_GAP + 1;
      m_accept  = 1;
    end else if (!m_active && k >= idle_from) begin
      if (sz >= PKT_WORDS) begin
        m_num = 16'(PKT_WORDS * 4);
        clr = 1;
        m_active = 1; start_edge = k; m_send_en = 1;
      end else if (m_pend) begin
        clr = 1;
        if (sz > 0) begin
          m_num = 16'(sz * 4);
          m_active = 1; start_edge = k; m_send_en = 1;
        end
      end
    end
    m_pend = f | (m_pend & !clr);
    if (w && sz == DEPTH) m_err[0] = 1'b1;
    if (r && sz == 0)     m_err[1] = 1'b1;
    if (r && sz > 0)      m_data = q.pop_front();
    if (w && sz < DEPTH)  q.push_back(d);
  endtask

  task automatic step(input logic w, input logic [31:0] d, input logic f,
                      input logic r, input logic e, input logic rs);
    wr_en = w; wr_data = d; flush = f; read_data_req = r; send_end = e; rst = rs;
    @(posedge clk);
    model_edge(w, d, f, r, e, rs);
    #1;
    check_eq("send_en",       send_en,       m_send_en);
    check_eq("send_data",     send_data,     m_data);
    check_eq("send_data_num", send_data_num, m_num);
    check_eq("fifo_full",     fifo_full,     q.size() == DEPTH);
    check_eq("busy",          busy,          m_active || (k < idle_from - 1));
    check_eq("pkt_cnt",       pkt_cnt,       m_pkt_cnt);
    check_eq("err",           err,           m_err);
    if (send_en) begin
      starts_seen++;
      last_num = send_data_num;
      if (last_end_edge >= 0) begin
        if (k - last_end_edge < min_gap) min_gap = k - last_end_edge;
        last_end_edge = -1;
      end
      $display("packet start at edge %0d: %0d bytes, pkt_cnt=%0d", k, send_data_num, pkt_cnt);
    end
    if (m_accept) last_end_edge = k;
    if (m_send_en) begin
      ds_left = int'(m_num) / 4;
      ds_wait = 1;
    end
    if (rs) begin
      ds_left = 0;
      ds_wait = 0;
      last_end_edge = -1;
    end
  endtask

  task automatic auto_step(input logic w, input logic [31:0] d, input logic f,
                           input int rd_pct, input int end_pct);
    logic r, e;
    r = 0; e = 0;
    if (ds_left > 0 && int'($urandom_range(99)) < rd_pct) begin
      r = 1; ds_left--;
    end else if (ds_left == 0 && ds_wait && int'($urandom_range(99)) < end_pct) begin
      e = 1; ds_wait = 0;
    end
    step(w, d, f, r, e, 1'b0);
  endtask

  task automatic drain(input string tag, input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget; i++) begin
      if (!ds_wait && ds_left == 0 && !m_active && k >= idle_from &&
          q.size() < PKT_WORDS && !m_pend) begin
        done = 1;
        break;
      end
      auto_step(1'b0, '0, 1'b0, 100, 100);
    end
    check_eq(tag, done, 1'b1);
  endtask

  initial begin
    int s0;
    logic w, f;
    logic [31:0] d;

    // Reset values.
    step(0, '0, 0, 0, 0, 1);
    check_eq("rst_send_data", send_data, 32'h0);
    check_eq("rst_num", send_data_num, 16'h0);
    check_eq("rst_busy", busy, 1'b0);
    step(0, '0, 0, 0, 0, 0);

    // One full packet of 0x1..0x100.
    s0 = starts_seen;
    for (int i = 1; i <= 256; i++) auto_step(1, 32'(i), 0, 100, 100);
    drain("full_pkt_drain", 2000);
    check_eq("full_pkt_starts", starts_seen - s0, 1);
    check_eq("full_pkt_num", last_num, 16'd1024);
    check_eq("full_pkt_cnt", pkt_cnt, 16'd1);

    // Partial packet by flush, then a flush on an empty FIFO.
    s0 = starts_seen;
    for (int i = 0; i < 10; i++) auto_step(1, 32'hA000_0000 + 32'(i), 0, 100, 100);
    auto_step(0, '0, 1, 100, 100);
    drain("flush_drain", 500);
    check_eq("flush_starts", starts_seen - s0, 1);
    check_eq("flush_num", last_num, 16'd40);
    s0 = starts_seen;
    auto_step(0, '0, 1, 100, 100);
    for (int i = 0; i < 30; i++) auto_step(0, '0, 0, 100, 100);
    check_eq("empty_flush_starts", starts_seen - s0, 0);

    // 600 continuous words: two packets, gap honoured, 88 words left.
    s0 = starts_seen;
    min_gap = 1000000;
    last_end_edge = -1;
    for (int i = 0; i < 600; i++) auto_step(1, 32'h5000_0000 + 32'(i), 0, 100, 100);
    drain("stream_drain", 3000);
    check_eq("stream_starts", starts_seen - s0, 2);
    check_eq("stream_gap_ok", min_gap >= IDLE_GAP + 1, 1'b1);
    auto_step(0, '0, 1, 100, 100);
    drain("stream_rest_drain", 500);
    check_eq("stream_rest_num", last_num, 16'd352);

    // Overflow then underflow.
    for (int i = 0; i < DEPTH; i++) step(1, 32'hC000_0000 + 32'(i), 0, 0, 0, 0);
    check_eq("ovf_full", fifo_full, 1'b1);
    check_eq("ovf_err_before", err, 2'b00);
    step(1, 32'hDEAD_BEEF, 0, 0, 0, 0);
    check_eq("ovf_full_after", fifo_full, 1'b1);
    check_eq("ovf_err", err, 2'b01);
    for (int i = 0; i < DEPTH; i++) step(0, '0, 0, 1, 0, 0);
    check_eq("ovf_empty_full", fifo_full, 1'b0);
    step(0, '0, 0, 1, 0, 0);
    check_eq("udf_err", err, 2'b11);
    ds_left = 0;
    ds_wait = 0;
    step(0, '0, 0, 0, 1, 0);
    drain("ovf_drain", 200);

    // Reset while waiting for send_end.
    for (int i = 0; i < 256; i++) auto_step(1, 32'(i), 0, 0, 0);
    for (int i = 0; i < 20 && !(m_active && k >= start_edge + 2); i++) auto_step(0, '0, 0, 0, 0);
    check_eq("wait_end_reached", m_active && busy, 1'b1);
    step(0, '0, 0, 0, 0, 1);
    check_eq("mid_rst_send_en", send_en, 1'b0);
    check_eq("mid_rst_data", send_data, 32'h0);
    check_eq("mid_rst_num", send_data_num, 16'h0);
    check_eq("mid_rst_pkt_cnt", pkt_cnt, 16'h0);
    check_eq("mid_rst_err", err, 2'b00);
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_full", fifo_full, 1'b0);
    s0 = starts_seen;
    step(0, '0, 0, 0, 1, 0);
    check_eq("post_rst_end_pkt_cnt", pkt_cnt, 16'h0);
    for (int i = 0; i < 40; i++) step(0, '0, 0, 0, 0, 0);
    check_eq("post_rst_starts", starts_seen - s0, 0);

    // Random traffic including stray requests, stray send_end and resets.
    for (int i = 0; i < 4000; i++) begin
      w = 1'($urandom_range(1));
      d = $urandom;
      f = ($urandom_range(99) == 0);
      if ($urandom_range(999) == 0)       step(0, '0, 0, 0, 0, 1);
      else if ($urandom_range(99) < 2)    step(w, d, f, 1, 0, 0);
      else if ($urandom_range(99) < 2)    step(w, d, f, 0, 1, 0);
      else                                auto_step(w, d, f, 70, 30);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
